shift_unit_seq: RTL and testbench
=================================

Name: shift_unit_seq

Overview:
- Parametrised, multi-cycle shift/rotate execution unit for the CPU datapath ALU.
- Generalises the single-purpose arithmetic-shift-right path to five modes: SHR, SHRA, SHL, ROR, ROL.
- Shifts by at most STEP bits per clock and reports completion through a start/busy/done handshake, so the control sequencer can stall its T-state until done.
- Result feeds the Z-low register input; carry_out and zero feed the condition/branch logic.

Parameters:
- WIDTH, 32, operand and result width in bits; must be ≥2.
- STEP, 4, maximum bits shifted per clock; must be a power of two, 1..WIDTH.
- AMT_W, $clog2(WIDTH), derived localparam; shift-amount field width. Not overridable.

Ports:
- clk  in  1  system clock, rising-edge active.
- clr  in  1  synchronous active-high reset.
- start  in  1  request pulse; sampled only when the unit is not busy.
- mode  in  3  operation select; encoding lives in the package.
- a  in  WIDTH  value to shift.
- b  in  WIDTH  shift amount; only b[AMT_W-1:0] is used, upper bits ignored.
- busy  out  1  high while in SHIFT.
- done  out  1  one-cycle completion pulse.
- result  out  WIDTH  shifted value; held until the next accepted start.
- carry_out  out  1  last bit shifted out (shifts) or last bit wrapped (rotates).
- zero  out  1  result == 0; registered alongside result.
- illegal  out  1  mode was an unused encoding; set with done.

Behaviour:
- Reset: clk and clr, synchronous and active-high. While clr=1 at a rising edge:
  - state is set to IDLE;
  - busy=0, done=0, result=0, carry_out=0, zero=1, illegal=0.
  - clr takes priority over start and aborts any SHIFT in progress with no done pulse.
- States: IDLE, SHIFT, DONE.
- start acceptance:
  - A start in IDLE or DONE is accepted at the edge.
  - start during SHIFT is ignored and not queued.
- On acceptance at edge k:
  - latch a into the working register, mode into mode_r, and amt = b[AMT_W-1:0] into rem;
  - clear carry_out.
- Transition after acceptance:
  - if amt==0 or the mode is illegal, go to DONE;
  - otherwise go to SHIFT.
- SHIFT, each edge:
  - s = min(STEP, rem); rem -= s; apply the s-bit operation.
  - The carry register takes the last bit out or wrapped in that step.
  - When rem reaches 0, go to DONE and register result, zero and carry_out.
- Latency: done is high in the cycle after edge k+n, where n = ceil(amt/STEP). For n=0, done follows edge k directly.
- DONE:
  - done=1 for exactly one cycle, then IDLE, unless start is sampled that same edge, which launches a new operation.
  - result, carry_out, zero and illegal persist until the next acceptance.
- Mode semantics:
  - SHR: zero-fill.
  - SHRA: fill with the latched a[WIDTH-1].
  - SHL: zero-fill from the LSB.
  - ROR / ROL: circular rotation.
- carry_out values:
  - SHR/SHRA by amt: a[amt-1].
  - SHL: a[WIDTH-amt].
  - ROR: result[WIDTH-1].
  - ROL: result[0].
  - amt=0: 0.
- Illegal mode: result=a, carry_out=0, illegal=1, done after edge k.
- Inputs a, b and mode may change freely after acceptance; they are not reused.

Decomposition:
- Package shift_pkg:
  - mode encoding localparams: SHR=3'd0, SHRA=3'd1, SHL=3'd2, ROR=3'd3, ROL=3'd4; 5–7 are illegal.
  - state encoding: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
- Sub-module shift_step:
  - purely combinational single-step shifter;
  - inputs: value, mode, s (0..STEP);
  - outputs: shifted value and the bit last out/wrapped.
  - The FSM wrapper instantiates it once.

Test Plan:
- SHRA, WIDTH=32, STEP=4: a=0x80000000, b=0x14 → busy for 5 cycles, done after edge k+5, result=0xFFFFF800, carry_out=0, zero=0.
- SHRA positive operand: a=0x00000012, b=0x14 → result=0x00000000, zero=1, carry_out=0, done after edge k+5. Then b=0x00000021 (amt=1) → result=0x00000009, carry_out=0, done after edge k+1.
- ROL: a=0x80000001, b=1 → result=0x00000003, carry_out=1, done after edge k+1. SHL: a=0x00000001, b=31 → result=0x80000000, carry_out=0, n=8.
- amt=0 and illegal mode:
  - a=0x1234ABCD, b=0x20, mode=SHR → done after edge k, result=0x1234ABCD, carry_out=0;
  - mode=3'd6 → same result, plus illegal=1.
- Handshake:
  - start re-pulsed while busy is ignored, and the first result is unchanged;
  - back-to-back start during DONE launches the second operation with no IDLE cycle.
- Reset mid-operation: SHR, a=0xFFFFFFFF, b=28; assert clr for one edge after 3 SHIFT cycles → busy=0, done never pulses, result=0, zero=1. A subsequent start behaves normally.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared encodings for the sequential shift/rotate unit: operation modes and FSM states.
package shift_pkg;

    localparam logic [2:0] MODE_SHR  = 3'd0;
    localparam logic [2:0] MODE_SHRA = 3'd1;
    localparam logic [2:0] MODE_SHL  = 3'd2;
    localparam logic [2:0] MODE_ROR  = 3'd3;
    localparam logic [2:0] MODE_ROL  = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic mode_is_legal(input logic [2:0] mode);
        return (mode <= MODE_ROL);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves the value by s bits (0..STEP) in the
// selected mode and reports the bit that was last shifted out or wrapped around.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    localparam int SW   = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic [2:0]       i_mode,
    input  logic [SW-1:0]    i_s,
    output logic [WIDTH-1:0] o_shifted,
    output logic             o_bit
);

    logic signed [WIDTH-1:0] w_value_s;
    logic [WIDTH-1:0]        w_srl;
    logic [WIDTH-1:0]        w_sra;
    logic [WIDTH-1:0]        w_sll;
    logic [WIDTH-1:0]        w_ror;
    logic [WIDTH-1:0]        w_rol;
    logic [WIDTH-1:0]        w_lo_probe;
    logic [WIDTH-1:0]        w_hi_probe;

    assign w_value_s = i_value;
    assign w_srl     = i_value >> i_s;
    assign w_sra     = w_value_s >>> i_s;
    assign w_sll     = i_value << i_s;
    assign w_ror     = w_srl | (i_value << (WIDTH - int'(i_s)));
    assign w_rol     = w_sll | (i_value >> (WIDTH - int'(i_s)));

    // Bring bit s-1 to the LSB and bit WIDTH-s to the MSB; those are the bits
    // leaving (or wrapping) on right and left moves respectively.
    assign w_lo_probe = i_value >> (int'(i_s) - 1);
    assign w_hi_probe = i_value << (int'(i_s) - 1);

    always_comb begin
        o_shifted = i_value;
        o_bit     = 1'b0;
        if (i_s != '0) begin
            case (i_mode)
                MODE_SHR: begin
                    o_shifted = w_srl;
                    o_bit     = w_lo_probe[0];
                end
                MODE_SHRA: begin
                    o_shifted = w_sra;
                    o_bit     = w_lo_probe[0];
                end
                MODE_SHL: begin
                    o_shifted = w_sll;
                    o_bit     = w_hi_probe[WIDTH-1];
                end
                MODE_ROR: begin
                    o_shifted = w_ror;
                    o_bit     = w_lo_probe[0];
                end
                MODE_ROL: begin
                    o_shifted = w_rol;
                    o_bit     = w_hi_probe[WIDTH-1];
                end
                default: begin
                    o_shifted = i_value;
                    o_bit     = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/shift_unit_seq.sv
// Multi-cycle shift/rotate unit: shifts at most STEP bits per clock and signals
// completion with a start/busy/done handshake for the control sequencer.
module shift_unit_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             illegal
);

    localparam int AMT_W = $clog2(WIDTH);
    localparam int SW    = $clog2(STEP + 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_work;
    logic [2:0]       r_mode;
    logic [AMT_W-1:0] r_rem;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic             r_carry_out;
    logic             r_zero;
    logic             r_illegal;

    logic [AMT_W-1:0] w_amt;
    logic             w_legal;
    logic [SW-1:0]    w_s;
    logic [AMT_W-1:0] w_rem_next;
    logic [WIDTH-1:0] w_shifted;
    logic             w_bit;
    logic             w_unused_b;

    assign w_amt      = b[AMT_W-1:0];
    assign w_unused_b = ^b[WIDTH-1:AMT_W];
    assign w_legal    = mode_is_legal(mode);

    // Step size is the smaller of STEP and the bits still to move.
    assign w_s        = (int'(r_rem) < STEP) ? SW'(r_rem) : SW'(STEP);
    assign w_rem_next = r_rem - AMT_W'(w_s);

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .i_value   (r_work),
        .i_mode    (r_mode),
        .i_s       (w_s),
        .o_shifted (w_shifted),
        .o_bit     (w_bit)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_zero      <= 1'b1;
            r_illegal   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_work      <= a;
                        r_mode      <= mode;
                        r_rem       <= w_amt;
                        r_carry_out <= 1'b0;
                        if ((w_amt == '0) || !w_legal) begin
                            // Nothing to move: complete straight away with a passed through.
                            r_state   <= DONE;
                            r_done    <= 1'b1;
                            r_busy    <= 1'b0;
                            r_result  <= a;
                            r_zero    <= (a == '0);
                            r_illegal <= !w_legal;
                        end else begin
                            r_state   <= SHIFT;
                            r_busy    <= 1'b1;
                            r_illegal <= 1'b0;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SHIFT: begin
                    r_work <= w_shifted;
                    r_rem  <= w_rem_next;
                    if (w_rem_next == '0) begin
                        r_state     <= DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_result    <= w_shifted;
                        r_zero      <= (w_shifted == '0);
                        r_carry_out <= w_bit;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign carry_out = r_carry_out;
    assign zero      = r_zero;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Scoreboard bench for shift_unit_seq: the driver queues hand-computed expectations,
// a negedge monitor pops and checks them whenever done pulses.
module tb_shift_unit_seq;
    import shift_pkg::*;

    logic        clk;
    logic        clr;
    logic        start;
    logic [2:0]  mode;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        carry_out;
    logic        zero;
    logic        illegal;

    shift_unit_seq #(
        .WIDTH (32),
        .STEP  (4)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .zero      (zero),
        .illegal   (illegal)
    );

    typedef struct {
        int          id;
        logic [31:0] res;
        logic        cy;
        logic        z;
        logic        ill;
        int          cyc;
        int          n;
    } exp_t;

    exp_t q[$];
    int   cyc      = 0;
    int   busy_cnt = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int id, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (op %0d): got 0x%08h, expected 0x%08h", name, id, act, exp);
        end
    endtask

    // Monitor: compare every done pulse against the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (clr) busy_cnt = 0;
        else if (busy) busy_cnt++;
        if (done) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, expected no pulse", cyc);
            end else begin
                e = q.pop_front();
                check("result",    e.id, result,          e.res);
                check("carry_out", e.id, 32'(carry_out),  32'(e.cy));
                check("zero",      e.id, 32'(zero),       32'(e.z));
                check("illegal",   e.id, 32'(illegal),    32'(e.ill));
                check("latency",   e.id, 32'(cyc),        32'(e.cyc));
                check("busy_cycles", e.id, 32'(busy_cnt), 32'(e.n));
            end
            busy_cnt = 0;
        end
    end

    // Called #1 after a rising edge; start is sampled on the next edge.
    task automatic issue(input int id, input logic [2:0] m, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] res, input logic cy,
                         input logic z, input logic ill, input int n);
        exp_t e;
        mode  = m;
        a     = av;
        b     = bv;
        start = 1'b1;
        e.id = id; e.res = res; e.cy = cy; e.z = z; e.ill = ill; e.n = n;
        e.cyc = cyc + 1 + n;
        q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 32'hDEAD_BEEF;
        b     = 32'h0000_0007;
        mode  = MODE_ROL;
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
            q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_idle_state(input int id);
        @(negedge clk);
        check("rst_busy",    id, 32'(busy),      32'd0);
        check("rst_done",    id, 32'(done),      32'd0);
        check("rst_result",  id, result,         32'd0);
        check("rst_carry",   id, 32'(carry_out), 32'd0);
        check("rst_zero",    id, 32'(zero),      32'd1);
        check("rst_illegal", id, 32'(illegal),   32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; mode = MODE_SHR; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b0;
        check_idle_state(0);

        issue(1,  MODE_SHRA, 32'h8000_0000, 32'h0000_0014, 32'hFFFF_F800, 1'b0, 1'b0, 1'b0, 5);
        drain();
        issue(2,  MODE_SHRA, 32'h0000_0012, 32'h0000_0014, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 5);
        drain();
        issue(3,  MODE_SHRA, 32'h0000_0012, 32'h0000_0021, 32'h0000_0009, 1'b0, 1'b0, 1'b0, 1);
        drain();
        issue(4,  MODE_ROL,  32'h8000_0001, 32'h0000_0001, 32'h0000_0003, 1'b1, 1'b0, 1'b0, 1);
        drain();
        issue(5,  MODE_SHL,  32'h0000_0001, 32'd31,        32'h8000_0000, 1'b0, 1'b0, 1'b0, 8);
        drain();
        issue(6,  MODE_SHR,  32'h1234_ABCD, 32'h0000_0020, 32'h1234_ABCD, 1'b0, 1'b0, 1'b0, 0);
        drain();
        issue(7,  3'd6,      32'h1234_ABCD, 32'h0000_0020, 32'h1234_ABCD, 1'b0, 1'b0, 1'b1, 0);
        drain();
        issue(8,  3'd7,      32'h0000_0000, 32'h0000_0003, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 0);
        drain();
        issue(9,  MODE_SHR,  32'hF000_0000, 32'd4,         32'h0F00_0000, 1'b0, 1'b0, 1'b0, 1);
        drain();
        issue(10, MODE_SHR,  32'h0000_000F, 32'd4,         32'h0000_0000, 1'b1, 1'b1, 1'b0, 1);
        drain();
        issue(11, MODE_ROR,  32'h0000_0001, 32'd1,         32'h8000_0000, 1'b1, 1'b0, 1'b0, 1);
        drain();
        issue(12, MODE_ROR,  32'h1234_5678, 32'd8,         32'h7812_3456, 1'b0, 1'b0, 1'b0, 2);
        drain();
        issue(13, MODE_ROL,  32'h1234_5678, 32'd4,         32'h2345_6781, 1'b1, 1'b0, 1'b0, 1);
        drain();
        issue(14, MODE_SHL,  32'hC000_0000, 32'd2,         32'h0000_0000, 1'b1, 1'b1, 1'b0, 1);
        drain();
        issue(15, MODE_SHRA, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 8);
        drain();
        issue(16, MODE_SHL,  32'h0000_0003, 32'd5,         32'h0000_0060, 1'b0, 1'b0, 1'b0, 2);
        drain();

        // A second start while busy must be dropped without disturbing the first op.
        issue(17, MODE_SHRA, 32'h8000_0000, 32'h0000_0014, 32'hFFFF_F800, 1'b0, 1'b0, 1'b0, 5);
        @(posedge clk);
        #1;
        mode = MODE_SHL; a = 32'hFFFF_FFFF; b = 32'd1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain();
        repeat (10) @(posedge clk);
        #1;

        // Back-to-back: second start lands in the DONE cycle of the first.
        issue(18, MODE_ROL,  32'h8000_0001, 32'd1,         32'h0000_0003, 1'b1, 1'b0, 1'b0, 1);
        @(posedge clk);
        #1;
        issue(19, MODE_SHR,  32'h8000_0000, 32'd8,         32'h0080_0000, 1'b0, 1'b0, 1'b0, 2);
        drain();

        // Abort mid-operation: no expectation is queued, so any done pulse is flagged.
        mode = MODE_SHR; a = 32'hFFFF_FFFF; b = 32'd28; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check_idle_state(20);
        repeat (12) @(posedge clk);
        #1;

        issue(21, MODE_SHR,  32'hFFFF_FFFF, 32'd28,        32'h0000_000F, 1'b1, 1'b0, 1'b0, 7);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
